// File: rtl/sram_mem_multiport_pkg.sv
// Shared types and helpers for the multiport SRAM subsystem.
// Holds the response metadata bundle and the byte-address to word-index map.
package sram_mem_multiport_pkg;

    localparam int MaxPorts = 8;
    localparam int PortIdW  = $clog2(MaxPorts);

    typedef struct packed {
        logic               valid;
        logic [PortIdW-1:0] port_id;
        logic               err;
    } resp_meta_t;

    // off is already relocated; the shift drops the byte-in-word bits.
    function automatic logic [63:0] addr_to_idx(
        input logic [63:0] off,
        input int unsigned shift
    );
        return off >> shift;
    endfunction

endpackage

// File: rtl/sram_mem_multiport_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer.
// Ports: clk, rst (sync, high), req, advance (a grant was taken), gnt.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] nxt;
    logic          found;
    int            j;

    always_comb begin
        gnt   = '0;
        nxt   = ptr;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                nxt    = PW'((j + 1) % N);
            end
        end
        if (rst) begin
            gnt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= nxt;
        end
    end

endmodule

// File: rtl/sram_mem_multiport.sv
// Shared single-ported word SRAM behind a round-robin arbiter.
// Ports: clk_i, rst_i, per-port req/we/addr/wdata/strb in; gnt/rvalid/rdata/err out.
module sram_mem_multiport
    import sram_mem_multiport_pkg::*;
#(
    parameter int NumPorts    = 2,
    parameter int DataWidth   = 32,
    parameter int AddrWidth   = 32,
    parameter int Depth       = 1 << 20,
    parameter int ReadLatency = 1,
    parameter logic [AddrWidth-1:0] RelocateBase = AddrWidth'(32'h8000_0000)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumPorts-1:0]               req_i,
    input  logic [NumPorts-1:0]               we_i,
    input  logic [NumPorts*AddrWidth-1:0]     addr_i,
    input  logic [NumPorts*DataWidth-1:0]     wdata_i,
    input  logic [NumPorts*DataWidth/8-1:0]   strb_i,
    output logic [NumPorts-1:0]               gnt_o,
    output logic [NumPorts-1:0]               rvalid_o,
    output logic [NumPorts*DataWidth-1:0]     rdata_o,
    output logic [NumPorts-1:0]               err_o
);

    localparam int ByteW = DataWidth / 8;
    localparam int Shift = $clog2(ByteW);
    localparam int IdxW  = (Depth > 1) ? $clog2(Depth) : 1;

    logic [NumPorts-1:0]  gnt;
    logic                 fire;
    logic                 sel_we;
    logic [AddrWidth-1:0] sel_addr;
    logic [AddrWidth-1:0] off;
    logic [DataWidth-1:0] sel_wdata;
    logic [ByteW-1:0]     sel_strb;
    logic [PortIdW-1:0]   sel_id;
    logic [63:0]          idx;
    logic                 in_range;
    logic [IdxW-1:0]      widx;

    logic [DataWidth-1:0] mem [Depth];

    resp_meta_t           meta_q [ReadLatency];
    logic [DataWidth-1:0] data_q [ReadLatency];
    resp_meta_t           last;

    rr_arbiter #(
        .N(NumPorts)
    ) u_arb (
        .clk    (clk_i),
        .rst    (rst_i),
        .req    (req_i),
        .advance(fire),
        .gnt    (gnt)
    );

    assign gnt_o = gnt;
    assign fire  = |gnt;

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_strb  = '0;
        sel_id    = '0;
        for (int p = 0; p < NumPorts; p++) begin
            if (gnt[p]) begin
                sel_we    = we_i[p];
                sel_addr  = addr_i[p*AddrWidth +: AddrWidth];
                sel_wdata = wdata_i[p*DataWidth +: DataWidth];
                sel_strb  = strb_i[p*ByteW +: ByteW];
                sel_id    = PortIdW'(p);
            end
        end
    end

    // Below-base addresses wrap to a huge offset and land out of range.
    assign off      = sel_addr - RelocateBase;
    assign idx      = addr_to_idx(64'(off), Shift);
    assign in_range = idx < 64'(Depth);
    assign widx     = idx[IdxW-1:0];

    always_ff @(posedge clk_i) begin
        if (fire && sel_we && in_range) begin
            for (int b = 0; b < ByteW; b++) begin
                if (sel_strb[b]) begin
                    mem[widx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Stage 0 captures the array at the grant edge; later stages only delay.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ReadLatency; i++) begin
                meta_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            meta_q[0] <= '{valid: fire, port_id: sel_id,
                           err: fire && !in_range};
            data_q[0] <= (fire && !sel_we && in_range) ? mem[widx] : '0;
            for (int i = 1; i < ReadLatency; i++) begin
                meta_q[i] <= meta_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign last = meta_q[ReadLatency-1];

    always_comb begin
        rvalid_o = '0;
        err_o    = '0;
        rdata_o  = '0;
        for (int p = 0; p < NumPorts; p++) begin
            if (last.valid && int'(last.port_id) == p) begin
                rvalid_o[p] = 1'b1;
                err_o[p]    = last.err;
                rdata_o[p*DataWidth +: DataWidth] = data_q[ReadLatency-1];
            end
        end
    end

endmodule

// File: tb/tb_sram_mem_multiport.sv
// Randomized and directed bench for sram_mem_multiport at latencies 1 and 3.
// Both DUTs share stimulus; a word-array model predicts grants and responses.
module tb_sram_mem_multiport;

    localparam int NP    = 3;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 64;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP-1:0]     req = '0;
    logic [NP-1:0]     we = '0;
    logic [NP*AW-1:0]  addr = '0;
    logic [NP*DW-1:0]  wdata = '0;
    logic [NP*4-1:0]   strb = '0;

    logic [NP-1:0]     g1, rv1, er1;
    logic [NP*DW-1:0]  rd1;
    logic [NP-1:0]     g3, rv3, er3;
    logic [NP*DW-1:0]  rd3;

    always #5 clk = ~clk;

    sram_mem_multiport #(
        .NumPorts(NP), .DataWidth(DW), .AddrWidth(AW), .Depth(DEPTH),
        .ReadLatency(1), .RelocateBase(BASE)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .strb_i(strb), .gnt_o(g1), .rvalid_o(rv1),
        .rdata_o(rd1), .err_o(er1)
    );

    sram_mem_multiport #(
        .NumPorts(NP), .DataWidth(DW), .AddrWidth(AW), .Depth(DEPTH),
        .ReadLatency(3), .RelocateBase(BASE)
    ) u_dut3 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .strb_i(strb), .gnt_o(g3), .rvalid_o(rv3),
        .rdata_o(rd3), .err_o(er3)
    );

    logic [31:0]   mem_m [DEPTH];
    int            ptr = 0;
    int            t = 0;
    bit            armed = 0;
    logic [NP-1:0] last_g = '0;
    logic [NP-1:0] obs_g1 = '0;
    int            lat [2] = '{1, 3};
    bit            s_v    [2][32];
    int            s_port [2][32];
    bit            s_err  [2][32];
    logic [31:0]   s_data [2][32];
    logic [31:0]   last_rd [2][NP];
    logic          last_er [2][NP];
    int            n_chk = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d got %0h exp %0h", tag, t, got, exp);
        end
    endtask

    function automatic logic [NP-1:0] model_gnt();
        if (rst) return '0;
        for (int i = 0; i < NP; i++) begin
            int j = (ptr + i) % NP;
            if (req[j]) return NP'(1) << j;
        end
        return '0;
    endfunction

    task automatic check_resp(input int d);
        logic [NP-1:0]    rvv, erv, exp_rv;
        logic [NP*DW-1:0] rdv;
        int k = t % 32;
        rvv = (d == 1) ? rv3 : rv1;
        erv = (d == 1) ? er3 : er1;
        rdv = (d == 1) ? rd3 : rd1;
        exp_rv = s_v[d][k] ? (NP'(1) << s_port[d][k]) : '0;
        chk(d ? "rvalid_l3" : "rvalid_l1", 64'(rvv), 64'(exp_rv));
        if (s_v[d][k]) begin
            int p = s_port[d][k];
            chk(d ? "err_l3" : "err_l1", 64'(erv[p]), 64'(s_err[d][k]));
            chk(d ? "rdata_l3" : "rdata_l1", 64'(rdv[p*DW +: DW]),
                64'(s_data[d][k]));
            last_rd[d][p] = rdv[p*DW +: DW];
            last_er[d][p] = erv[p];
        end
    endtask

    task automatic step();
        logic [NP-1:0] eg;
        @(negedge clk);
        eg = model_gnt();
        obs_g1 = g1;
        chk("gnt_l1", 64'(g1), 64'(eg));
        chk("gnt_l3", 64'(g3), 64'(eg));
        for (int d = 0; d < 2; d++) begin
            if (armed) check_resp(d);
            s_v[d][t % 32] = 0;
        end
        last_g = eg;
        if (rst) begin
            ptr = 0;
            armed = 1;
            for (int d = 0; d < 2; d++)
                for (int k = 1; k <= 4; k++) s_v[d][(t + k) % 32] = 0;
        end else if (eg != '0) begin
            int p = 0;
            logic [31:0] a, off, wd, rdat;
            logic [3:0]  s;
            bit oor;
            for (int i = 0; i < NP; i++) if (eg[i]) p = i;
            a   = addr[p*AW +: AW];
            wd  = wdata[p*DW +: DW];
            s   = strb[p*4 +: 4];
            off = a - BASE;
            oor = (off >> 2) >= DEPTH;
            rdat = '0;
            if (!oor && !we[p]) rdat = mem_m[off >> 2];
            if (!oor && we[p])
                for (int b = 0; b < 4; b++)
                    if (s[b]) mem_m[off >> 2][b*8 +: 8] = wd[b*8 +: 8];
            for (int d = 0; d < 2; d++) begin
                int k = (t + lat[d]) % 32;
                s_v[d][k]    = 1;
                s_port[d][k] = p;
                s_err[d][k]  = oor;
                s_data[d][k] = rdat;
            end
            ptr = (p + 1) % NP;
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    function automatic logic [31:0] wa(input int i);
        return BASE + 32'(4 * i);
    endfunction

    task automatic set_port(input int p, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        req[p] = r;
        we[p]  = w;
        addr[p*AW +: AW] = a;
        wdata[p*DW +: DW] = d;
        strb[p*4 +: 4] = s;
    endtask

    task automatic xfer(input int p, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        set_port(p, 1'b1, w, a, d, s);
        do begin
            step();
            n++;
        end while (!last_g[p] && n < 8);
        chk("grant_wait", 64'(last_g[p]), 64'd1);
        req[p] = 1'b0;
    endtask

    task automatic drain(input int n);
        req = '0;
        repeat (n) step();
    endtask

    task automatic rand_port(input int p);
        logic [31:0] a;
        int k = $urandom_range(0, 9);
        if (k < 8) a = wa($urandom_range(0, DEPTH-1)) + 32'($urandom_range(0, 3));
        else if (k == 8) a = BASE - 32'(4 * $urandom_range(1, 4));
        else a = wa(DEPTH + $urandom_range(0, 3));
        set_port(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a,
                 $urandom, 4'($urandom_range(0, 15)));
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            set_port(0, 1'b1, 1'b1, wa(i), $urandom, 4'hF);
            step();
        end
        drain(4);

        set_port(1, 1'b1, 1'b0, wa(5), 32'h0, 4'h0);
        step();
        req = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (5) begin
            step();
            chk("idle_rvalid", 64'({rv1, rv3}), 64'd0);
            chk("idle_err", 64'({er1, er3}), 64'd0);
            chk("idle_rdata", 64'(rd1 | rd3), 64'd0);
        end

        xfer(0, 1'b1, 32'h8000_0010, 32'hDEADBEEF, 4'hF);
        xfer(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0);
        drain(4);
        for (int d = 0; d < 2; d++) begin
            chk("deadbeef_data", 64'(last_rd[d][0]), 64'hDEADBEEF);
            chk("deadbeef_err", 64'(last_er[d][0]), 64'd0);
        end

        xfer(1, 1'b1, wa(9), 32'hFFFFFFFF, 4'hF);
        xfer(1, 1'b1, wa(9), 32'h11223344, 4'b0101);
        xfer(1, 1'b0, wa(9), 32'h0, 4'h0);
        drain(4);
        for (int d = 0; d < 2; d++)
            chk("partial_data", 64'(last_rd[d][1]), 64'hFF22FF44);

        xfer(2, 1'b0, wa(1), 32'h0, 4'h0);
        set_port(0, 1'b1, 1'b0, wa(2), 32'h0, 4'h0);
        set_port(1, 1'b1, 1'b0, wa(3), 32'h0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("alt_gnt", 64'(obs_g1), (i % 2) ? 64'b010 : 64'b001);
        end
        drain(4);

        xfer(0, 1'b1, BASE - 32'd4, 32'h0, 4'hF);
        xfer(0, 1'b1, wa(DEPTH), 32'h0, 4'hF);
        xfer(0, 1'b0, BASE - 32'd4, 32'h0, 4'h0);
        drain(4);
        for (int d = 0; d < 2; d++) begin
            chk("oor_lo_err", 64'(last_er[d][0]), 64'd1);
            chk("oor_lo_data", 64'(last_rd[d][0]), 64'd0);
        end
        xfer(0, 1'b0, wa(DEPTH), 32'h0, 4'h0);
        drain(4);
        for (int d = 0; d < 2; d++) begin
            chk("oor_hi_err", 64'(last_er[d][0]), 64'd1);
            chk("oor_hi_data", 64'(last_rd[d][0]), 64'd0);
        end
        xfer(0, 1'b0, wa(0), 32'h0, 4'h0);
        xfer(0, 1'b0, wa(DEPTH-1), 32'h0, 4'h0);
        drain(4);

        for (int i = 0; i < 4; i++) begin
            set_port(0, 1'b1, 1'b0, wa(i), 32'h0, 4'h0);
            step();
        end
        drain(5);
        chk("b2b_last", 64'(last_rd[1][0]), 64'(mem_m[3]));

        repeat (800) begin
            for (int p = 0; p < NP; p++)
                if (!(req[p] && !last_g[p])) rand_port(p);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        drain(6);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
